sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
Parametrised single-clock FIFO; successor to the fixed 8-bit buffer used by the existing datapath. Adds a selectable read mode: registered-output or first-word-fall-through (FWFT). Adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Sits between producer and consumer blocks in one clock domain.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (16)
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL
FWFT, 0, 0 = registered read (data one cycle after accept); 1 = first-word-fall-through

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
wq  in  1  write request
w_data  in  DATA_W  write data
rq  in  1  read request
clr_err  in  1  synchronous clear of overflow/underflow
r_data  out  DATA_W  read data
r_valid  out  1  r_data holds a valid popped/head word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=0, asynchronous): wr/rd pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, r_data=0, r_valid=0, overflow=0, underflow=0.
- Reset does not clear memory contents. Reset mid-operation discards all stored words; the first read after release returns the first word written after release.
- rd_acc = rq & ~empty.
- wr_acc = wq & (~full | rd_acc): a write while full is accepted only if a read is accepted in the same cycle.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- count next value:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither
- full, empty, almost_full and almost_empty are derived from registered count; they update on the edge after the access.
- Simultaneous wq/rq while empty: write accepted, read rejected, underflow set; empty deasserts the next cycle.
- Simultaneous wq/rq while full: both accepted; count stays DEPTH; full stays 1.
- FWFT=0:
  - On rd_acc, r_data <= mem[rd_ptr] at that edge; r_valid=1 for exactly that following cycle.
  - Otherwise r_valid=0 and r_data holds its last value.
  - Latency from write edge to earliest read data: 2 cycles.
- FWFT=1:
  - r_data = mem[rd_ptr] combinationally; r_valid = ~empty.
  - rq acts as pop/acknowledge; the next head word appears after the popping edge.
  - Latency from write edge to head visible: 1 cycle.
- overflow set when wq & ~wr_acc; underflow set when rq & empty. Both are sticky until clr_err.
- If clr_err coincides with a new error event, the set wins.
- Rejected accesses never move pointers or corrupt memory.
- Threshold legality (checked by elaboration assertion): 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.

Test Plan:
- Reset then idle, FWFT=0 -> empty=1, almost_empty=1, count=0, r_valid=0, r_data=0; one rq -> underflow=1, count stays 0; clr_err one cycle -> underflow=0.
- Write 1,2, then 3 reads, FWFT=0 -> r_data 1 then 2 with one-cycle r_valid pulses; third read rejected, underflow=1.
- Write 10,20..160 (16 words) -> almost_full rises when count hits 14, full at 16; 17th write rejected with overflow=1; drain returns 10..160 in order (pointer wrap checked by a second fill after 5 pops).
- Full FIFO with simultaneous wq=1 (data 170) and rq=1 -> pops oldest, count stays 16, full=1, overflow=0; 170 emerges last.
- FWFT=1: write 5 -> r_valid=1 and r_data=5 one cycle after the write edge with no rq; rq pops it -> empty=1, r_valid=0 next cycle.
- Fill 8 words, assert rst=0 mid-burst asynchronously -> all flags/count return to reset values immediately; after release, write 42 and read -> 42.

Source files
------------

// File: rtl/sync_fifo_flags_if.sv
// Signal bundle between sync_fifo_flags and its producer/consumer logic.
// The FIFO takes the slave view; the block driving requests takes the master view.
interface sync_fifo_flags_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wq;
    logic [DATA_W-1:0] w_data;
    logic              rq;
    logic              clr_err;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wq, w_data, rq, clr_err,
        input  r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wq, w_data, rq, clr_err,
        output r_data, r_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_flags #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_flags_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_CNT = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AF_CNT    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0]   AE_CNT    = AE_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

    generate
        if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
            $error("sync_fifo_flags: thresholds must satisfy 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("sync_fifo_flags: FWFT must be 0 or 1");
        end
    endgenerate

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              empty_w;
    logic              full_w;
    logic              rd_acc;
    logic              wr_acc;

    // Status comes straight off the registered count, so it moves on the edge after an access.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_CNT);

    assign rd_acc = bus.rq & ~empty_w;
    // A full FIFO still takes a write when the same edge frees a slot.
    assign wr_acc = bus.wq & (~full_w | rd_acc);

    // NOTE: storage has no reset; stale words are unreachable once the pointers and count clear.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.w_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;

            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase

            // A new error event in the same cycle as clr_err keeps the flag set.
            if (bus.wq & ~wr_acc)   overflow_q <= 1'b1;
            else if (bus.clr_err)   overflow_q <= 1'b0;

            if (bus.rq & empty_w)   underflow_q <= 1'b1;
            else if (bus.clr_err)   underflow_q <= 1'b0;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [DATA_W-1:0] r_data_q;
            logic              r_valid_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= rd_acc;
                    if (rd_acc) r_data_q <= mem[rd_ptr];
                end
            end

            assign bus.r_data  = r_data_q;
            assign bus.r_valid = r_valid_q;
        end else begin : g_fwft_read
            // Head word is always presented; rq only acknowledges and advances.
            assign bus.r_data  = mem[rd_ptr];
            assign bus.r_valid = ~empty_w;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= AF_CNT);
    assign bus.almost_empty = (count_q <= AE_CNT);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives one stimulus stream into a registered-read and an FWFT instance and
// compares both against a queue-based model of the FIFO.
module tb_sync_fifo_flags;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wq = 1'b0;
    logic       rq = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] w_data = 8'd0;

    int checks = 0;
    int errors = 0;

    // Reference model: stored words in order, sticky flags, last popped word.
    logic [7:0] mq[$];
    bit         m_ovf, m_unf, m_rv;
    logic [7:0] m_rd;

    sync_fifo_flags_if #(.DATA_W(8), .ADDR_W(4)) b0 ();
    sync_fifo_flags_if #(.DATA_W(8), .ADDR_W(4)) b1 ();

    assign b0.wq = wq;  assign b0.w_data = w_data;  assign b0.rq = rq;  assign b0.clr_err = clr_err;
    assign b1.wq = wq;  assign b1.w_data = w_data;  assign b1.rq = rq;  assign b1.clr_err = clr_err;

    sync_fifo_flags #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
        u_dut_reg (.clk(clk), .rst(rst), .bus(b0));
    sync_fifo_flags #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1))
        u_dut_fwft (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    function automatic void model_reset();
        mq.delete();
        m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = 8'd0;
    endfunction

    function automatic void model_step(bit w, logic [7:0] d, bit r, bit c);
        int n = mq.size();
        bit rd = r && (n > 0);
        bit wr = w && ((n < 16) || rd);
        if (w && !wr) m_ovf = 1; else if (c) m_ovf = 0;
        if (r && n == 0) m_unf = 1; else if (c) m_unf = 0;
        m_rv = rd;
        if (rd) m_rd = mq.pop_front();
        if (wr) mq.push_back(d);
    endfunction

    function automatic logic [19:0] exp0();
        int n = mq.size();
        return {5'(n), n == 16, n == 0, n >= 14, n <= 2, m_ovf, m_unf, m_rv, m_rd};
    endfunction

    function automatic logic [11:0] exp1();
        int n = mq.size();
        return {5'(n), n == 16, n == 0, n >= 14, n <= 2, m_ovf, m_unf, n > 0};
    endfunction

    function automatic logic [19:0] snap0();
        return {b0.count, b0.full, b0.empty, b0.almost_full, b0.almost_empty,
                b0.overflow, b0.underflow, b0.r_valid, b0.r_data};
    endfunction

    function automatic logic [11:0] snap1();
        return {b1.count, b1.full, b1.empty, b1.almost_full, b1.almost_empty,
                b1.overflow, b1.underflow, b1.r_valid};
    endfunction

    // One clock: apply inputs, take the edge, advance the model, settle, go idle.
    task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
        wq = w; w_data = d; rq = r; clr_err = c;
        @(posedge clk);
        model_step(w, d, r, c);
        #1;
        wq = 0; rq = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (snap0() !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++; $display("FAIL reset_reg: got %h expected %h", snap0(), exp0());
        end
        checks++;
        if (snap1() !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_fwft: got %h expected %h", snap1(), exp1());
        end
        @(negedge clk) rst = 1'b1;
        drive(0, 8'd0, 1, 0);
        checks++;
        if ({b0.underflow, b0.count, b1.underflow, b1.count} !== {1'b1, 5'd0, 1'b1, 5'd0}) begin
            errors++; $display("FAIL underflow_set: got %b/%0d %b/%0d expected 1/0", b0.underflow, b0.count, b1.underflow, b1.count);
        end
        drive(0, 8'd0, 0, 1);
        checks++;
        if ({b0.underflow, b1.underflow} !== 2'b00) begin
            errors++; $display("FAIL underflow_clear: got %b%b expected 00", b0.underflow, b1.underflow);
        end
    endtask

    task automatic test_basic_read();
        drive(1, 8'd1, 0, 0);
        drive(1, 8'd2, 0, 0);
        drive(0, 8'd0, 1, 0);
        checks++;
        if ({b0.r_valid, b0.r_data} !== {1'b1, 8'd1}) begin
            errors++; $display("FAIL read1: got v=%b d=%0d expected v=1 d=1", b0.r_valid, b0.r_data);
        end
        drive(0, 8'd0, 1, 0);
        checks++;
        if ({b0.r_valid, b0.r_data} !== {1'b1, 8'd2}) begin
            errors++; $display("FAIL read2: got v=%b d=%0d expected v=1 d=2", b0.r_valid, b0.r_data);
        end
        drive(0, 8'd0, 1, 0);
        checks++;
        if ({b0.r_valid, b0.r_data, b0.underflow, b0.count} !== {1'b0, 8'd2, 1'b1, 5'd0}) begin
            errors++; $display("FAIL read3_rejected: got v=%b d=%0d u=%b c=%0d expected v=0 d=2 u=1 c=0",
                               b0.r_valid, b0.r_data, b0.underflow, b0.count);
        end
        drive(0, 8'd0, 0, 0);
        checks++;
        if ({b0.r_valid, b0.r_data} !== {1'b0, 8'd2}) begin
            errors++; $display("FAIL read_hold: got v=%b d=%0d expected v=0 d=2", b0.r_valid, b0.r_data);
        end
        drive(0, 8'd0, 0, 1);
    endtask

    task automatic test_fill_wrap();
        for (int i = 1; i <= 16; i++) begin
            drive(1, 8'(i * 10), 0, 0);
            checks++;
            if ({b0.count, b0.almost_full, b0.full, b0.empty} !== {5'(i), i >= 14, i == 16, 1'b0}) begin
                errors++; $display("FAIL fill_%0d: got c=%0d af=%b f=%b e=%b expected c=%0d af=%b f=%b e=0",
                                   i, b0.count, b0.almost_full, b0.full, b0.empty, i, i >= 14, i == 16);
            end
        end
        drive(1, 8'd99, 0, 0);
        checks++;
        if ({b0.overflow, b0.count, b1.overflow} !== {1'b1, 5'd16, 1'b1}) begin
            errors++; $display("FAIL overflow_17th: got o=%b c=%0d expected o=1 c=16", b0.overflow, b0.count);
        end
        drive(0, 8'd0, 0, 1);
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (b1.r_data !== 8'(i * 10)) begin
                errors++; $display("FAIL fwft_head_%0d: got %0d expected %0d", i, b1.r_data, i * 10);
            end
            drive(0, 8'd0, 1, 0);
            checks++;
            if ({b0.r_valid, b0.r_data} !== {1'b1, 8'(i * 10)}) begin
                errors++; $display("FAIL drain_%0d: got v=%b d=%0d expected v=1 d=%0d", i, b0.r_valid, b0.r_data, i * 10);
            end
        end
        // Second pass starts mid-array so the write pointer wraps while words are still stored.
        for (int i = 0; i < 16; i++) drive(1, 8'(100 + i), 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 8'd0, 1, 0);
        for (int i = 0; i < 5; i++) drive(1, 8'(120 + i), 0, 0);
        checks++;
        if ({b0.count, b0.full} !== {5'd16, 1'b1}) begin
            errors++; $display("FAIL refill: got c=%0d f=%b expected c=16 f=1", b0.count, b0.full);
        end
        for (int k = 0; k < 16; k++) begin
            drive(0, 8'd0, 1, 0);
            checks++;
            if (b0.r_data !== ((k < 11) ? 8'(105 + k) : 8'(120 + k - 11))) begin
                errors++; $display("FAIL wrap_drain_%0d: got %0d expected %0d", k, b0.r_data,
                                   (k < 11) ? 105 + k : 120 + k - 11);
            end
        end
    endtask

    task automatic test_full_rw();
        for (int i = 1; i <= 16; i++) drive(1, 8'(i), 0, 0);
        drive(1, 8'd170, 1, 0);
        checks++;
        if ({b0.count, b0.full, b0.overflow, b0.r_valid, b0.r_data} !== {5'd16, 1'b1, 1'b0, 1'b1, 8'd1}) begin
            errors++; $display("FAIL full_rw: got c=%0d f=%b o=%b v=%b d=%0d expected c=16 f=1 o=0 v=1 d=1",
                               b0.count, b0.full, b0.overflow, b0.r_valid, b0.r_data);
        end
        for (int k = 0; k < 16; k++) begin
            drive(0, 8'd0, 1, 0);
            checks++;
            if (b0.r_data !== ((k < 15) ? 8'(k + 2) : 8'd170)) begin
                errors++; $display("FAIL full_rw_drain_%0d: got %0d expected %0d", k, b0.r_data, (k < 15) ? k + 2 : 170);
            end
        end
    endtask

    task automatic test_fwft();
        drive(1, 8'd5, 0, 0);
        checks++;
        if ({b1.r_valid, b1.r_data, b0.r_valid} !== {1'b1, 8'd5, 1'b0}) begin
            errors++; $display("FAIL fwft_head: got v=%b d=%0d reg_v=%b expected v=1 d=5 reg_v=0", b1.r_valid, b1.r_data, b0.r_valid);
        end
        drive(0, 8'd0, 0, 0);
        checks++;
        if ({b1.r_valid, b1.r_data} !== {1'b1, 8'd5}) begin
            errors++; $display("FAIL fwft_hold: got v=%b d=%0d expected v=1 d=5", b1.r_valid, b1.r_data);
        end
        drive(0, 8'd0, 1, 0);
        checks++;
        if ({b1.r_valid, b1.empty, b0.r_valid, b0.r_data} !== {1'b0, 1'b1, 1'b1, 8'd5}) begin
            errors++; $display("FAIL fwft_pop: got v=%b e=%b reg_v=%b reg_d=%0d expected v=0 e=1 reg_v=1 reg_d=5",
                               b1.r_valid, b1.empty, b0.r_valid, b0.r_data);
        end
        // Write and read together on an empty FIFO: write lands, read is an underflow.
        drive(1, 8'd9, 1, 0);
        checks++;
        if ({b0.count, b0.empty, b0.underflow, b0.r_valid} !== {5'd1, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL empty_rw: got c=%0d e=%b u=%b v=%b expected c=1 e=0 u=1 v=0",
                               b0.count, b0.empty, b0.underflow, b0.r_valid);
        end
        // Error re-raised in the same cycle as clr_err stays set.
        drive(0, 8'd0, 1, 1);
        drive(0, 8'd0, 1, 1);
        checks++;
        if ({b0.underflow, b1.underflow} !== 2'b11) begin
            errors++; $display("FAIL set_beats_clear: got %b%b expected 11", b0.underflow, b1.underflow);
        end
        drive(0, 8'd0, 0, 1);
    endtask

    task automatic test_random();
        int pw = 70, pr = 30;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 60 == 0) begin
                pw = (cyc % 120 == 0) ? 75 : 25;
                pr = 100 - pw;
            end
            drive($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                  $urandom_range(0, 19) == 0);
            checks++;
            if (snap0() !== exp0()) begin
                errors++; $display("FAIL random_reg cyc %0d: got %h expected %h", cyc, snap0(), exp0());
            end
            checks++;
            if (snap1() !== exp1()) begin
                errors++; $display("FAIL random_fwft cyc %0d: got %h expected %h", cyc, snap1(), exp1());
            end
            if (mq.size() > 0) begin
                checks++;
                if (b1.r_data !== mq[0]) begin
                    errors++; $display("FAIL random_fwft_head cyc %0d: got %0d expected %0d", cyc, b1.r_data, mq[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) drive(1, 8'(60 + i), 0, 0);
        wq = 1; w_data = 8'd77;
        #3 rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (snap0() !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            errors++; $display("FAIL async_reset_reg: got %h expected %h", snap0(), exp0());
        end
        checks++;
        if (snap1() !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL async_reset_fwft: got %h expected %h", snap1(), exp1());
        end
        @(posedge clk);
        #1 wq = 0;
        @(negedge clk) rst = 1'b1;
        drive(1, 8'd42, 0, 0);
        checks++;
        if ({b1.r_valid, b1.r_data, b0.count} !== {1'b1, 8'd42, 5'd1}) begin
            errors++; $display("FAIL post_reset_fwft: got v=%b d=%0d c=%0d expected v=1 d=42 c=1", b1.r_valid, b1.r_data, b0.count);
        end
        drive(0, 8'd0, 1, 0);
        checks++;
        if ({b0.r_valid, b0.r_data, b0.empty} !== {1'b1, 8'd42, 1'b1}) begin
            errors++; $display("FAIL post_reset_read: got v=%b d=%0d e=%b expected v=1 d=42 e=1", b0.r_valid, b0.r_data, b0.empty);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_fill_wrap();
        test_full_rw();
        test_fwft();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
